player_anim_sequencer: RTL and testbench

Per-frame animation sequencer for the player sprite. It runs at the frame clock and tracks the player's motion state (idle, running, airborne), facing direction and current animation frame. It produces the `animationOffset` word base that the player sprite address generator adds to the in-sprite pixel offset, so it sits directly upstream of that stage.

---
 rtl/player_anim_pkg.sv | 24 ++
 rtl/player_anim_sequencer_tick_divider.sv | 32 +++
 rtl/player_anim_sequencer.sv | 144 ++++++++++++++
 tb/tb_player_anim_sequencer.sv | 184 ++++++++++++++++++
 4 files changed

// File: rtl/player_anim_pkg.sv
// Shared types and default sheet layout constants for the player sprite animation path.
package player_anim_pkg;

    typedef enum logic [1:0] {
        ANIM_IDLE = 2'd0,
        ANIM_RUN  = 2'd1,
        ANIM_JUMP = 2'd2
    } anim_state_t;

    // Sheet layout: 24 x 45 words per frame, left sheet follows the right one.
    localparam int unsigned DEFAULT_FRAME_WORDS = 32'd1080;
    localparam int unsigned DEFAULT_RIGHT_BASE  = 32'd0;
    localparam int unsigned DEFAULT_LEFT_BASE   = 32'd20736;

    function automatic logic [31:0] frame_word_base(
        input logic [31:0] dir_base,
        input logic [31:0] seq_base,
        input logic [2:0]  frame,
        input logic [31:0] frame_words
    );
        return dir_base + ((seq_base + {29'd0, frame}) * frame_words);
    endfunction

endpackage

// File: rtl/player_anim_sequencer_tick_divider.sv
// Tick counter that paces animation frames; hold has priority over clear.
module anim_tick_divider #(
    parameter int unsigned TICKS = 32'd6
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic hold,
    output logic terminal
);

    localparam int unsigned CW = (TICKS > 32'd1) ? $clog2(TICKS) : 32'd1;
    localparam logic [CW-1:0] LAST = CW'(TICKS - 32'd1);

    logic [CW-1:0] count_r;

    // Count ticks, wrapping to zero on the terminal tick.
    always_ff @(posedge clk) begin
        if (reset) begin
            count_r <= '0;
        end else if (hold) begin
            count_r <= count_r;
        end else if (clear || terminal) begin
            count_r <= '0;
        end else begin
            count_r <= count_r + CW'(1);
        end
    end

    assign terminal = (count_r == LAST);

endmodule

// File: rtl/player_anim_sequencer.sv
// Player sprite animation sequencer: motion FSM, frame stepping and the
// word base handed to the sprite address generator.
module player_anim_sequencer
    import player_anim_pkg::*;
#(
    parameter int unsigned FRAME_WORDS     = DEFAULT_FRAME_WORDS,
    parameter int unsigned RIGHT_BASE      = DEFAULT_RIGHT_BASE,
    parameter int unsigned LEFT_BASE       = DEFAULT_LEFT_BASE,
    parameter int unsigned IDLE_BASE       = 32'd0,
    parameter int unsigned RUN_BASE        = 32'd1,
    parameter int unsigned RUN_FRAMES      = 32'd6,
    parameter int unsigned JUMP_BASE       = 32'd7,
    parameter int unsigned JUMP_FRAMES     = 32'd4,
    parameter int unsigned TICKS_PER_FRAME = 32'd6
) (
    input  logic        frame_Clk,
    input  logic        Reset,
    input  logic        playerDirection,
    input  logic        moveReq,
    input  logic        airborne,
    input  logic        freeze,
    output logic [31:0] animationOffset,
    output logic [1:0]  animState,
    output logic [2:0]  frameIndex,
    output logic        frameStrobe
);

    anim_state_t state_r;
    anim_state_t next_state_s;
    anim_state_t target_s;
    logic [2:0]  frame_r;
    logic [2:0]  next_frame_s;
    logic [2:0]  last_frame_s;
    logic        dir_r;
    logic        next_dir_s;
    logic        strobe_r;
    logic        next_strobe_s;
    logic        change_s;
    logic        tick_clear_s;
    logic        terminal_s;
    logic [31:0] seq_base_s;
    logic [31:0] dir_base_s;

    // Target state from the motion inputs: airborne beats horizontal motion.
    always_comb begin
        target_s = ANIM_IDLE;
        if (airborne) begin
            target_s = ANIM_JUMP;
        end else if (moveReq) begin
            target_s = ANIM_RUN;
        end else begin
            target_s = ANIM_IDLE;
        end
    end

    assign change_s     = (target_s != state_r);
    assign tick_clear_s = change_s || (state_r == ANIM_IDLE);

    anim_tick_divider #(
        .TICKS (TICKS_PER_FRAME)
    ) u_tick (
        .clk      (frame_Clk),
        .reset    (Reset),
        .clear    (tick_clear_s),
        .hold     (freeze),
        .terminal (terminal_s)
    );

    // Last frame index of the sequence currently playing.
    always_comb begin
        case (state_r)
            ANIM_RUN:  last_frame_s = 3'(RUN_FRAMES - 32'd1);
            ANIM_JUMP: last_frame_s = 3'(JUMP_FRAMES - 32'd1);
            default:   last_frame_s = 3'd0;
        endcase
    end

    // Next-state and frame stepping; a state change wins over a terminal tick.
    always_comb begin
        next_state_s  = state_r;
        next_frame_s  = frame_r;
        next_dir_s    = dir_r;
        next_strobe_s = 1'b0;
        if (freeze) begin
            next_strobe_s = 1'b0;
        end else begin
            next_dir_s = playerDirection;
            if (change_s) begin
                next_state_s = target_s;
                next_frame_s = 3'd0;
            end else begin
                case (state_r)
                    ANIM_RUN, ANIM_JUMP: begin
                        if (terminal_s) begin
                            next_frame_s  = (frame_r == last_frame_s) ? 3'd0 : frame_r + 3'd1;
                            next_strobe_s = 1'b1;
                        end else begin
                            next_frame_s  = frame_r;
                        end
                    end
                    ANIM_IDLE: next_frame_s = 3'd0;
                    default: begin
                        next_state_s = ANIM_IDLE;
                        next_frame_s = 3'd0;
                    end
                endcase
            end
        end
    end

    // State, frame, direction and strobe registers.
    always_ff @(posedge frame_Clk) begin
        if (Reset) begin
            state_r  <= ANIM_IDLE;
            frame_r  <= 3'd0;
            dir_r    <= 1'b0;
            strobe_r <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            frame_r  <= next_frame_s;
            dir_r    <= next_dir_s;
            strobe_r <= next_strobe_s;
        end
    end

    // Output decode of the registered state.
    always_comb begin
        case (state_r)
            ANIM_RUN:  seq_base_s = 32'(RUN_BASE);
            ANIM_JUMP: seq_base_s = 32'(JUMP_BASE);
            default:   seq_base_s = 32'(IDLE_BASE);
        endcase
        if (dir_r) begin
            dir_base_s = 32'(LEFT_BASE);
        end else begin
            dir_base_s = 32'(RIGHT_BASE);
        end
        animationOffset = frame_word_base(dir_base_s, seq_base_s, frame_r, 32'(FRAME_WORDS));
        animState       = state_r;
        frameIndex      = frame_r;
        frameStrobe     = strobe_r;
    end

endmodule

// File: tb/tb_player_anim_sequencer.sv
// Self-checking bench: directed vector table, corner sequences, then random
// stimulus against a frame-level reference model.
module tb_player_anim_sequencer;

    logic        frame_Clk = 1'b0;
    logic        Reset = 1'b1;
    logic        playerDirection = 1'b0;
    logic        moveReq = 1'b0;
    logic        airborne = 1'b0;
    logic        freeze = 1'b0;
    logic [31:0] animationOffset;
    logic [1:0]  animState;
    logic [2:0]  frameIndex;
    logic        frameStrobe;

    int compared = 0;
    int mismatched = 0;

    player_anim_sequencer dut (
        .frame_Clk       (frame_Clk),
        .Reset           (Reset),
        .playerDirection (playerDirection),
        .moveReq         (moveReq),
        .airborne        (airborne),
        .freeze          (freeze),
        .animationOffset (animationOffset),
        .animState       (animState),
        .frameIndex      (frameIndex),
        .frameStrobe     (frameStrobe)
    );

    always #5 frame_Clk = ~frame_Clk;

    typedef struct {
        logic        rst;
        logic        dir;
        logic        move;
        logic        air;
        logic        frz;
        int          cycles;
        int unsigned off;
        int          st;
        int          fr;
        logic        sb;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic dir, input logic move, input logic air,
                       input logic frz, input int cycles, input int unsigned off,
                       input int st, input int fr, input logic sb);
        vec_t v;
        v.rst = rst; v.dir = dir; v.move = move; v.air = air; v.frz = frz;
        v.cycles = cycles; v.off = off; v.st = st; v.fr = fr; v.sb = sb;
        vecs.push_back(v);
    endtask

    task automatic drive(input logic rst, input logic dir, input logic move, input logic air,
                         input logic frz);
        Reset = rst; playerDirection = dir; moveReq = move; airborne = air; freeze = frz;
    endtask

    task automatic check(input string name, input int unsigned e_off, input int e_st,
                         input int e_fr, input logic e_sb);
        compared++;
        if (animationOffset !== e_off || animState !== 2'(e_st) ||
            frameIndex !== 3'(e_fr) || frameStrobe !== e_sb) begin
            mismatched++;
            $display("FAIL %s: got off=%0d st=%0d fr=%0d strobe=%0b, want off=%0d st=%0d fr=%0d strobe=%0b",
                     name, animationOffset, animState, frameIndex, frameStrobe,
                     e_off, e_st, e_fr, e_sb);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge frame_Clk);
        #1;
    endtask

    // Reference model state, kept as plain integers.
    int m_st, m_fr, m_tick;
    logic m_dir, m_sb;

    function automatic int unsigned model_offset();
        int unsigned seq;
        seq = (m_st == 1) ? 1 : (m_st == 2) ? 7 : 0;
        return (m_dir ? 32'd20736 : 32'd0) + (seq + m_fr) * 32'd1080;
    endfunction

    task automatic model_step(input logic rst, input logic dir, input logic move,
                              input logic air, input logic frz);
        int target, len;
        if (rst) begin
            m_st = 0; m_fr = 0; m_tick = 0; m_dir = 1'b0; m_sb = 1'b0;
        end else if (frz) begin
            m_sb = 1'b0;
        end else begin
            target = air ? 2 : (move ? 1 : 0);
            m_dir = dir;
            m_sb = 1'b0;
            if (target != m_st) begin
                m_st = target; m_fr = 0; m_tick = 0;
            end else if (m_st == 0) begin
                m_fr = 0; m_tick = 0;
            end else begin
                len = (m_st == 1) ? 6 : 4;
                m_tick = m_tick + 1;
                if (m_tick == 6) begin
                    m_tick = 0;
                    m_fr = (m_fr + 1) % len;
                    m_sb = 1'b1;
                end
            end
        end
    endtask

    initial begin
        // rst dir mv air frz cycles offset st fr sb
        add(1, 0, 0, 0, 0, 1,     0, 0, 0, 0);
        add(0, 0, 1, 0, 0, 1,  1080, 1, 0, 0);
        add(0, 0, 1, 0, 0, 5,  1080, 1, 0, 0);
        add(0, 0, 1, 0, 0, 1,  2160, 1, 1, 1);
        add(0, 0, 1, 0, 0, 1,  2160, 1, 1, 0);
        add(0, 0, 1, 0, 0, 29, 1080, 1, 0, 1);
        add(0, 0, 1, 0, 0, 12, 3240, 1, 2, 1);
        add(0, 1, 1, 0, 0, 1, 23976, 1, 2, 0);
        add(0, 1, 1, 0, 0, 4, 23976, 1, 2, 0);
        add(0, 1, 1, 0, 0, 1, 25056, 1, 3, 1);
        add(0, 1, 1, 0, 0, 5, 25056, 1, 3, 0);
        add(0, 0, 1, 1, 0, 1,  7560, 2, 0, 0);
        add(0, 0, 0, 1, 0, 24, 7560, 2, 0, 1);
        add(0, 0, 0, 1, 0, 18, 10800, 2, 3, 1);
        add(0, 0, 0, 1, 0, 2, 10800, 2, 3, 0);
        add(0, 1, 1, 0, 1, 5, 10800, 2, 3, 0);
        add(0, 0, 0, 1, 1, 5, 10800, 2, 3, 0);
        add(0, 0, 0, 1, 0, 3, 10800, 2, 3, 0);
        add(0, 0, 0, 1, 0, 1,  7560, 2, 0, 1);
        add(0, 1, 1, 0, 0, 1, 21816, 1, 0, 0);
        add(0, 1, 1, 0, 0, 24, 26136, 1, 4, 1);
        add(1, 1, 1, 0, 1, 1,     0, 0, 0, 0);

        foreach (vecs[i]) begin
            drive(vecs[i].rst, vecs[i].dir, vecs[i].move, vecs[i].air, vecs[i].frz);
            tick(vecs[i].cycles);
            check($sformatf("vec%0d", i), vecs[i].off, vecs[i].st, vecs[i].fr, vecs[i].sb);
        end

        // Dropping motion on the terminal tick goes straight to IDLE without a strobe.
        drive(0, 0, 1, 0, 0);
        tick(6);
        check("run_pre_terminal", 1080, 1, 0, 0);
        drive(0, 0, 0, 0, 0);
        tick(1);
        check("idle_over_terminal", 0, 0, 0, 0);
        drive(0, 0, 1, 0, 0);
        tick(1);
        check("idle_to_run", 1080, 1, 0, 0);
        drive(0, 1, 1, 1, 1);
        tick(1);
        check("freeze_over_change", 1080, 1, 0, 0);

        // Random stimulus against the reference model.
        drive(1, 0, 0, 0, 0);
        model_step(1, 0, 0, 0, 0);
        tick(1);
        check("rand_reset", model_offset(), m_st, m_fr, m_sb);
        for (int c = 0; c < 3000; c++) begin
            logic r_rst, r_dir, r_move, r_air, r_frz;
            r_rst  = ($urandom_range(0, 63) == 0);
            r_frz  = ($urandom_range(0, 7) == 0);
            r_air  = ($urandom_range(0, 5) == 0);
            r_move = ($urandom_range(0, 3) != 0);
            r_dir  = ($urandom_range(0, 15) == 0) ? ~playerDirection : playerDirection;
            drive(r_rst, r_dir, r_move, r_air, r_frz);
            model_step(r_rst, r_dir, r_move, r_air, r_frz);
            tick(1);
            check($sformatf("rand%0d", c), model_offset(), m_st, m_fr, m_sb);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
